// File: rtl/prog_loader.sv
// prog_loader
// Streams a program image from a host into instruction memory (load mode) or
// reads it back and compares it against the host stream (verify mode), while
// holding the core in reset until a clean session has completed.
//
// Ports
//   clk, res                 clock, synchronous active-high reset
//   start, mode              session request (IDLE only); 0 = load, 1 = verify
//   start_adr, len           first word address and word count, sampled with start
//   in_valid, in_data        host word stream
//   in_ready                 host word accepted when in_valid && in_ready
//   mem_we, mem_adr          instruction-memory write enable / address
//   mem_wdata, mem_rdata     instruction-memory write / read data (read: 1-cycle latency)
//   cpu_hold                 core held in reset while high
//   busy, done               session active / one-cycle completion pulse
//   err, err_adr             sticky error flag / address of first error
//   checksum                 wrapping sum of accepted words
module prog_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] start_adr,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_adr,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {IDLE, LOAD, VRD, VCMP, FIN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] adr;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] sum_q;
    logic              err_q;
    logic [ADDR_W-1:0] err_adr_q;
    logic              hold_q;
    logic              released_q;  // a clean load has happened since reset
    logic              mode_q;

    logic              accept;
    logic              bad_len;
    logic              last_word;
    logic [ADDR_W-1:0] adr_inc;

    assign accept    = in_valid && in_ready;
    assign bad_len   = (len == '0) || (len > DEPTH_L);
    assign last_word = (cnt == (ADDR_W+1)'(1));
    // Wrap at the configured depth, not at the address-space size.
    assign adr_inc   = (adr == LAST_ADR) ? '0 : adr + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (res) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = bad_len ? FIN : (mode ? VRD : LOAD);
            LOAD: if (accept && last_word) state_nxt = FIN;
            VRD:  state_nxt = VCMP;
            VCMP: if (accept) state_nxt = last_word ? FIN : VRD;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs. Handshake and write enable are gated by res so that a word
    // presented on the reset edge is neither accepted nor written.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FIN);
        in_ready  = !res && ((state == LOAD) || (state == VCMP));
        mem_we    = !res && (state == LOAD) && in_valid;
        mem_adr   = ((state == LOAD) || (state == VRD) || (state == VCMP)) ? adr : '0;
        mem_wdata = in_data;
        cpu_hold  = hold_q;
        err       = err_q;
        err_adr   = err_adr_q;
        checksum  = sum_q;
    end

    // Session datapath
    always_ff @(posedge clk) begin
        if (res) begin
            adr        <= '0;
            cnt        <= '0;
            sum_q      <= '0;
            err_q      <= 1'b0;
            err_adr_q  <= '0;
            hold_q     <= 1'b1;
            released_q <= 1'b0;
            mode_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        hold_q <= 1'b1;
                        mode_q <= mode;
                        if (bad_len) begin
                            err_q     <= 1'b1;
                            err_adr_q <= start_adr;
                        end else begin
                            sum_q     <= '0;
                            err_q     <= 1'b0;
                            err_adr_q <= '0;
                            cnt       <= len;
                            adr       <= start_adr;
                        end
                    end
                end
                LOAD, VCMP: begin
                    if (accept) begin
                        sum_q <= sum_q + in_data;
                        adr   <= adr_inc;
                        cnt   <= cnt - 1'b1;
                        // mem_rdata belongs to adr: it was presented in VRD and
                        // held stable while waiting here.
                        if ((state == VCMP) && (in_data != mem_rdata) && !err_q) begin
                            err_q     <= 1'b1;
                            err_adr_q <= adr;
                        end
                    end
                end
                FIN: begin
                    // Release the core only after a clean session; before the
                    // first clean load, a verify alone cannot release it.
                    if (!err_q && (!mode_q || released_q)) begin
                        hold_q     <= 1'b0;
                        released_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a small behavioural instruction memory.
module tb_prog_loader;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DP = 12;

    logic          clk = 1'b0;
    logic          res;
    logic          start;
    logic          mode;
    logic [AW-1:0] start_adr;
    logic [AW:0]   len;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] err_adr;
    logic [DW-1:0] checksum;

    int n_chk  = 0;
    int n_pass = 0;

    prog_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .res(res), .start(start), .mode(mode), .start_adr(start_adr),
        .len(len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .err(err), .err_adr(err_adr), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Memory model: writes and write log taken mid-cycle, read data registered
    // on the rising edge (one cycle after the address is presented).
    logic [DW-1:0] mem [16];
    logic [AW-1:0] rd_pend = '0;
    logic [AW-1:0] wlog_a[$];
    logic [DW-1:0] wlog_d[$];
    int wcnt    = 0;
    int gap_err = 0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            mem[mem_adr] <= mem_wdata;
            wlog_a.push_back(mem_adr);
            wlog_d.push_back(mem_wdata);
            wcnt <= wcnt + 1;
            if (in_valid !== 1'b1) gap_err <= gap_err + 1;
        end
        rd_pend <= mem_adr;
    end

    always @(posedge clk) mem_rdata <= mem[rd_pend];

    function automatic logic [DW-1:0] w(int i);
        return 32'h8000_0000 | 32'(i + 1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_sess(input logic m, input logic [AW-1:0] a, input logic [AW:0] l);
        start = 1'b1; mode = m; start_adr = a; len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        res = 1'b1; start = 1'b0; mode = 1'b0; start_adr = '0; len = '0;
        in_valid = 1'b0; in_data = '0;
        tick(); tick();
        res = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL rst_done got %0b exp 0", done); else n_pass++;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %0b exp 0", in_ready); else n_pass++;
        n_chk++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %0b exp 0", mem_we); else n_pass++;
        n_chk++; if (mem_adr !== 4'd0) $display("FAIL rst_mem_adr got %0d exp 0", mem_adr); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL rst_err got %0b exp 0", err); else n_pass++;
        n_chk++; if (err_adr !== 4'd0) $display("FAIL rst_err_adr got %0d exp 0", err_adr); else n_pass++;
        n_chk++; if (checksum !== 32'd0) $display("FAIL rst_checksum got %h exp 0", checksum); else n_pass++;
        n_chk++; if (cpu_hold !== 1'b1) $display("FAIL rst_cpu_hold got %0b exp 1", cpu_hold); else n_pass++;
    endtask

    // 7 words at address 0, in_valid held high: one write per cycle.
    task automatic test_load;
        int base;
        base = wlog_a.size();
        start_sess(1'b0, 4'd0, 5'd7);
        n_chk++; if (busy !== 1'b1) $display("FAIL load_busy got %0b exp 1", busy); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL load_ready got %0b exp 1", in_ready); else n_pass++;
        n_chk++; if (mem_we !== 1'b0) $display("FAIL load_we_idle_valid got %0b exp 0", mem_we); else n_pass++;
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = w(i);
            #1;
            n_chk++;
            if ({mem_we, mem_adr, mem_wdata} !== {1'b1, 4'(i), w(i)})
                $display("FAIL load_wr%0d got we=%0b adr=%0d d=%h exp we=1 adr=%0d d=%h",
                         i, mem_we, mem_adr, mem_wdata, i, w(i));
            else n_pass++;
            tick();
        end
        n_chk++; if (done !== 1'b1) $display("FAIL load_done got %0b exp 1", done); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL load_fin_busy got %0b exp 1", busy); else n_pass++;
        n_chk++; if (mem_we !== 1'b0) $display("FAIL load_fin_we got %0b exp 0", mem_we); else n_pass++;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL load_fin_ready got %0b exp 0", in_ready); else n_pass++;
        n_chk++; if (checksum !== 32'h8000_001C) $display("FAIL load_checksum got %h exp 8000001c", checksum); else n_pass++;
        in_valid = 1'b0;
        tick();
        n_chk++; if (done !== 1'b0) $display("FAIL load_done_pulse got %0b exp 0", done); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL load_idle_busy got %0b exp 0", busy); else n_pass++;
        n_chk++; if (cpu_hold !== 1'b0) $display("FAIL load_cpu_hold got %0b exp 0", cpu_hold); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL load_err got %0b exp 0", err); else n_pass++;
        n_chk++; if (wlog_a.size() - base !== 7) $display("FAIL load_wr_count got %0d exp 7", wlog_a.size() - base); else n_pass++;
    endtask

    // Verify the image with word 4 corrupted.
    task automatic test_verify_err;
        int w0, idx, cyc;
        logic acc;
        w0 = wcnt; idx = 0; cyc = 0;
        start_sess(1'b1, 4'd0, 5'd7);
        n_chk++; if (cpu_hold !== 1'b1) $display("FAIL ver_hold_start got %0b exp 1", cpu_hold); else n_pass++;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL ver_vrd_ready got %0b exp 0", in_ready); else n_pass++;
        in_valid = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            in_data = (idx == 4) ? (w(4) ^ 32'hFF) : w(idx);
            acc = in_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        n_chk++; if (cyc !== 14) $display("FAIL ver_cycles got %0d exp 14", cyc); else n_pass++;
        n_chk++; if (idx !== 7) $display("FAIL ver_accepts got %0d exp 7", idx); else n_pass++;
        n_chk++; if (err !== 1'b1) $display("FAIL ver_err got %0b exp 1", err); else n_pass++;
        n_chk++; if (err_adr !== 4'd4) $display("FAIL ver_err_adr got %0d exp 4", err_adr); else n_pass++;
        n_chk++; if (checksum !== 32'h8000_0111) $display("FAIL ver_checksum got %h exp 80000111", checksum); else n_pass++;
        n_chk++; if (wcnt - w0 !== 0) $display("FAIL ver_no_write got %0d exp 0", wcnt - w0); else n_pass++;
        tick();
        n_chk++; if (cpu_hold !== 1'b1) $display("FAIL ver_hold_after got %0b exp 1", cpu_hold); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL ver_idle got %0b exp 0", busy); else n_pass++;
        n_chk++; if (err !== 1'b1) $display("FAIL ver_err_sticky got %0b exp 1", err); else n_pass++;
    endtask

    // Start two words below the top of a 12-word memory: wraps to 0.
    task automatic test_wrap;
        int base;
        logic [AW-1:0] exp_a[4];
        exp_a = '{4'd10, 4'd11, 4'd0, 4'd1};
        base = wlog_a.size();
        start_sess(1'b0, 4'd10, 5'd4);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        n_chk++; if (done !== 1'b1) $display("FAIL wrap_done got %0b exp 1", done); else n_pass++;
        n_chk++; if (wlog_a.size() - base !== 4) $display("FAIL wrap_count got %0d exp 4", wlog_a.size() - base); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (base + i >= wlog_a.size() || wlog_a[base+i] !== exp_a[i])
                $display("FAIL wrap_adr%0d got %0d exp %0d", i,
                         (base + i < wlog_a.size()) ? wlog_a[base+i] : 4'hx, exp_a[i]);
            else n_pass++;
        end
        tick();
        n_chk++; if (checksum !== 32'd10) $display("FAIL wrap_checksum got %h exp a", checksum); else n_pass++;
        n_chk++; if (cpu_hold !== 1'b0) $display("FAIL wrap_hold got %0b exp 0", cpu_hold); else n_pass++;
    endtask

    // len=0 and len=DEPTH+1 are rejected without touching memory.
    task automatic test_bad_len;
        logic [AW-1:0] a_t[2];
        logic [AW:0]   l_t[2];
        int w0;
        a_t = '{4'd5, 4'd7};
        l_t = '{5'd0, 5'd13};
        for (int k = 0; k < 2; k++) begin
            w0 = wcnt;
            start_sess(1'b0, a_t[k], l_t[k]);
            n_chk++; if (done !== 1'b1) $display("FAIL bad%0d_done got %0b exp 1", k, done); else n_pass++;
            n_chk++; if (err !== 1'b1) $display("FAIL bad%0d_err got %0b exp 1", k, err); else n_pass++;
            n_chk++; if (err_adr !== a_t[k]) $display("FAIL bad%0d_err_adr got %0d exp %0d", k, err_adr, a_t[k]); else n_pass++;
            tick();
            n_chk++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL bad%0d_idle got done=%0b busy=%0b exp 0 0", k, done, busy); else n_pass++;
            n_chk++; if (cpu_hold !== 1'b1) $display("FAIL bad%0d_hold got %0b exp 1", k, cpu_hold); else n_pass++;
            n_chk++; if (wcnt - w0 !== 0) $display("FAIL bad%0d_no_write got %0d exp 0", k, wcnt - w0); else n_pass++;
        end
    endtask

    // Load with in_valid gaps; a start pulse mid-session must be ignored.
    task automatic test_gaps;
        int base, g0, sent, cyc;
        logic acc;
        logic pv[10];
        pv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        base = wlog_a.size(); g0 = gap_err; sent = 0; cyc = 0;
        start_sess(1'b0, 4'd2, 5'd5);
        while (done !== 1'b1 && cyc < 30) begin
            in_valid = pv[cyc % 10];
            in_data  = 32'h100 + 32'(sent);
            if (cyc == 2) begin
                start = 1'b1; mode = 1'b1; start_adr = 4'd9; len = 5'd3;
            end
            acc = in_valid & in_ready;
            tick();
            start = 1'b0;
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        n_chk++; if (cyc !== 10) $display("FAIL gap_cycles got %0d exp 10", cyc); else n_pass++;
        n_chk++; if (gap_err - g0 !== 0) $display("FAIL gap_write_on_gap got %0d exp 0", gap_err - g0); else n_pass++;
        n_chk++; if (wlog_a.size() - base !== 5) $display("FAIL gap_count got %0d exp 5", wlog_a.size() - base); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (base + i >= wlog_a.size() || wlog_a[base+i] !== 4'(i + 2) || wlog_d[base+i] !== 32'h100 + 32'(i))
                $display("FAIL gap_wr%0d exp adr=%0d d=%h", i, i + 2, 32'h100 + 32'(i));
            else n_pass++;
        end
        n_chk++; if (checksum !== 32'h50A) $display("FAIL gap_checksum got %h exp 50a", checksum); else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL gap_idle got %0b exp 0", busy); else n_pass++;
        n_chk++; if (cpu_hold !== 1'b0) $display("FAIL gap_hold got %0b exp 0", cpu_hold); else n_pass++;
    endtask

    // Reset after the 3rd word of a 7-word load, then a fresh session.
    task automatic test_reset_mid;
        int base;
        base = wlog_a.size();
        start_sess(1'b0, 4'd0, 5'd7);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h40 + 32'(i);
            tick();
        end
        in_data = 32'h43;
        res = 1'b1;
        #1;
        n_chk++; if (mem_we !== 1'b0) $display("FAIL rmid_we_on_reset got %0b exp 0", mem_we); else n_pass++;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL rmid_ready_on_reset got %0b exp 0", in_ready); else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rmid_state got busy=%0b done=%0b exp 0 0", busy, done); else n_pass++;
        n_chk++; if (mem_adr !== 4'd0) $display("FAIL rmid_mem_adr got %0d exp 0", mem_adr); else n_pass++;
        n_chk++; if (err !== 1'b0 || err_adr !== 4'd0) $display("FAIL rmid_err got %0b/%0d exp 0/0", err, err_adr); else n_pass++;
        n_chk++; if (checksum !== 32'd0) $display("FAIL rmid_checksum got %h exp 0", checksum); else n_pass++;
        n_chk++; if (cpu_hold !== 1'b1) $display("FAIL rmid_hold got %0b exp 1", cpu_hold); else n_pass++;
        n_chk++; if (wlog_a.size() - base !== 3) $display("FAIL rmid_writes got %0d exp 3", wlog_a.size() - base); else n_pass++;
        res = 1'b0; in_valid = 1'b0;
        start_sess(1'b0, 4'd3, 5'd2);
        in_valid = 1'b1;
        in_data = 32'h55; tick();
        in_data = 32'hAA; tick();
        in_valid = 1'b0;
        n_chk++; if (done !== 1'b1) $display("FAIL rmid_new_done got %0b exp 1", done); else n_pass++;
        tick();
        n_chk++; if (checksum !== 32'hFF) $display("FAIL rmid_new_checksum got %h exp ff", checksum); else n_pass++;
        n_chk++; if (cpu_hold !== 1'b0) $display("FAIL rmid_new_hold got %0b exp 0", cpu_hold); else n_pass++;
        n_chk++;
        if (wlog_a.size() - base !== 5 || wlog_a[base+3] !== 4'd3 || wlog_a[base+4] !== 4'd4)
            $display("FAIL rmid_new_writes count=%0d exp 5 at adr 3,4", wlog_a.size() - base);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_verify_err();
        test_wrap();
        test_bad_len();
        test_gaps();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
